pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the five-stage core. Drives the per-stage stall vector and flush for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Accepts stall requests from IF, ID, EX and MEM. Accepts exception and ERET redirect requests from MEM.
- Runs a small FSM that holds flush for a programmable number of cycles and supplies the redirect PC.
- Watches for runaway stalls.

Parameters:
- FLUSH_CYCLES, 1, number of cycles flush stays asserted per redirect (1..15)
- STALL_MAX, 255, consecutive stalled cycles before stall_timeout sets (1..65535)

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stallreq_if  in  1  IF stage stall request
- stallreq_id  in  1  ID stage stall request
- stallreq_ex  in  1  EX stage stall request (multi-cycle ops)
- stallreq_mem  in  1  MEM stage stall request
- excp_req  in  1  exception taken in MEM, single-cycle pulse
- excp_vector  in  32  handler address for excp_req
- eret_req  in  1  ERET retiring in MEM, single-cycle pulse
- epc_i  in  32  return address for eret_req
- stall  out  6  [0]=PC, [1]=IF/ID, [2]=ID/EX, [3]=EX/MEM, [4]=MEM/WB, [5]=WB; 1 = hold
- flush  out  1  clear all pipeline registers to NOP/reset values
- new_pc  out  32  redirect target, valid while new_pc_valid
- new_pc_valid  out  1  one-cycle pulse, first flush cycle only
- stall_timeout  out  1  sticky watchdog flag
- busy  out  1  FSM not in RUN

Behaviour:
- Reset (async, rst=1): state=RUN, flush=0, new_pc=0, new_pc_valid=0, stall_timeout=0, stall counter=0, flush counter=0, pending latch cleared. stall reads 0 while in reset.
- States: RUN, FLUSH, DRAIN.
- Stall mapping, combinational, same cycle. Applies only in RUN with no redirect this cycle. The highest-numbered requesting stage wins:
  - mem: 6'b011111
  - ex: 6'b001111
  - id: 6'b000111
  - if: 6'b000011
  - none: 6'b000000
- RUN transitions:
  - excp_req=1 → FLUSH next cycle; new_pc<=excp_vector; new_pc_valid<=1; flush<=1.
  - Otherwise eret_req=1 → same, with new_pc<=epc_i.
  - excp_req has priority over eret_req when both are set.
  - A redirect overrides any stall request in the same cycle: stall=0 that cycle.
- FLUSH:
  - flush=1 and stall=0 for exactly FLUSH_CYCLES cycles.
  - new_pc_valid=1 only in the first of those cycles. new_pc holds its value until the next redirect.
  - Stall requests are ignored.
  - After FLUSH_CYCLES cycles → DRAIN.
- DRAIN: one cycle, flush=0, stall=0.
  - If the pending latch is set → FLUSH with the pending target, clear the latch.
  - Otherwise → RUN.
- Redirect while busy (FLUSH or DRAIN):
  - excp_req or eret_req is latched into the pending latch, target plus valid; excp beats eret.
  - A second request while pending is already set overwrites it only if it is excp_req.
- Watchdog:
  - The 16-bit counter increments each RUN cycle with stall!=0. It clears on any cycle with stall==0 or state!=RUN, and saturates.
  - When the counter reaches STALL_MAX, stall_timeout sets and stays set until rst.
- busy = (state!=RUN), registered-state derived.
- flush, new_pc, new_pc_valid and stall_timeout are registered. stall is combinational.
- Reset mid-FLUSH: immediate return to reset values; the pending latch is lost.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- Defined: adds outputs perf_stall_cnt[31:0] (RUN cycles with stall!=0) and perf_flush_cnt[31:0] (number of redirects taken, pending ones included). Both reset to 0 and wrap at 2^32.
- Undefined: ports absent, no counter logic.

Test Plan:
- Reset: rst=1 while stallreq_mem=1 → stall=0, flush=0, busy=0, new_pc=0. Release rst, stallreq_ex=1 → stall=6'b001111 the same cycle.
- Priority: stallreq_if=stallreq_id=stallreq_mem=1 → stall=6'b011111. Drop mem → 6'b000111.
- Exception: excp_req pulse, excp_vector=0x00000020, FLUSH_CYCLES=2 → next 2 cycles flush=1; new_pc_valid=1 in cycle 1 only; new_pc=0x20. Then one DRAIN cycle, then RUN.
- Simultaneous: excp_req=1 with eret_req=1 (epc_i=0x80001000), plus stallreq_mem=1 → stall=0 that cycle, new_pc=0x20.
- Pending: eret_req (epc_i=0x1234) during FLUSH → after DRAIN, a second FLUSH with new_pc=0x1234 and new_pc_valid pulse. perf_flush_cnt=2 when PIPE_CTRL_PERF_EN is defined.
- Watchdog: STALL_MAX=4, stallreq_ex held 4 cycles → stall_timeout=1 after the 4th cycle. Stays 1 after the request drops. Cleared only by rst.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Pipeline sequencer bus: stage stall requests and MEM redirects in; stall
// vector, flush, redirect PC and status out. With PIPE_CTRL_PERF_EN defined
// the two performance counters are carried as well.
interface pipe_ctrl_if;
   logic        stallreq_if;
   logic        stallreq_id;
   logic        stallreq_ex;
   logic        stallreq_mem;
   logic        excp_req;
   logic [31:0] excp_vector;
   logic        eret_req;
   logic [31:0] epc_i;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic        new_pc_valid;
   logic        stall_timeout;
   logic        busy;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] perf_stall_cnt;
   logic [31:0] perf_flush_cnt;

   // Core side: raises requests, consumes pipeline controls.
   modport master (
      output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
      output excp_req, excp_vector, eret_req, epc_i,
      input  stall, flush, new_pc, new_pc_valid, stall_timeout, busy,
      input  perf_stall_cnt, perf_flush_cnt
   );

   // Sequencer side.
   modport slave (
      input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
      input  excp_req, excp_vector, eret_req, epc_i,
      output stall, flush, new_pc, new_pc_valid, stall_timeout, busy,
      output perf_stall_cnt, perf_flush_cnt
   );
`else
   // Core side: raises requests, consumes pipeline controls.
   modport master (
      output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
      output excp_req, excp_vector, eret_req, epc_i,
      input  stall, flush, new_pc, new_pc_valid, stall_timeout, busy
   );

   // Sequencer side.
   modport slave (
      input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
      input  excp_req, excp_vector, eret_req, epc_i,
      output stall, flush, new_pc, new_pc_valid, stall_timeout, busy
   );
`endif
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: five-stage pipeline sequencer. Produces the per-stage stall
// vector, holds flush for FLUSH_CYCLES cycles per redirect, queues one
// redirect that arrives while busy, and flags runaway stalls.
// Optional: define PIPE_CTRL_PERF_EN for stall/redirect performance counters.
module pipe_ctrl #(
   parameter int FLUSH_CYCLES = 1,
   parameter int STALL_MAX    = 255
) (
   input  logic       clk,
   input  logic       rst,
   pipe_ctrl_if.slave bus
);
   localparam logic [1:0]  ST_RUN   = 2'd0;
   localparam logic [1:0]  ST_FLUSH = 2'd1;
   localparam logic [1:0]  ST_DRAIN = 2'd2;
   localparam logic [3:0]  FLUSH_LAST  = 4'(FLUSH_CYCLES);
   localparam logic [15:0] STALL_LIMIT = 16'(STALL_MAX);

   logic [1:0]  state_r;
   logic [3:0]  flush_cnt_r;
   logic        flush_r;
   logic [31:0] new_pc_r;
   logic        new_pc_valid_r;
   logic        pend_valid_r;
   logic [31:0] pend_pc_r;
   logic [15:0] wd_cnt_r;
   logic        stall_timeout_r;

   logic        redirect_req_s;
   logic [31:0] redirect_pc_s;
   logic [5:0]  stall_map_s;
   logic [5:0]  stall_s;
   logic        drain_go_s;
   logic [31:0] drain_pc_s;
   logic [15:0] wd_inc_s;

   assign redirect_req_s = bus.excp_req | bus.eret_req;
   assign redirect_pc_s  = bus.excp_req ? bus.excp_vector : bus.epc_i;
   assign wd_inc_s       = (wd_cnt_r == 16'hFFFF) ? wd_cnt_r : (wd_cnt_r + 16'd1);

   // Deepest requesting stage decides how much of the front of the pipe holds.
   always_comb begin
      stall_map_s = 6'b000000;
      if (bus.stallreq_mem) begin
         stall_map_s = 6'b011111;
      end else if (bus.stallreq_ex) begin
         stall_map_s = 6'b001111;
      end else if (bus.stallreq_id) begin
         stall_map_s = 6'b000111;
      end else if (bus.stallreq_if) begin
         stall_map_s = 6'b000011;
      end else begin
         stall_map_s = 6'b000000;
      end
   end

   // Stalls only apply while running normally; a redirect or reset wins.
   always_comb begin
      stall_s = 6'b000000;
      if (!rst && (state_r == ST_RUN) && !redirect_req_s) begin
         stall_s = stall_map_s;
      end else begin
         stall_s = 6'b000000;
      end
   end

   // Target leaving DRAIN: a fresh exception beats the latch, the latch beats a fresh ERET.
   always_comb begin
      drain_go_s = 1'b1;
      drain_pc_s = pend_pc_r;
      if (bus.excp_req) begin
         drain_pc_s = bus.excp_vector;
      end else if (pend_valid_r) begin
         drain_pc_s = pend_pc_r;
      end else if (bus.eret_req) begin
         drain_pc_s = bus.epc_i;
      end else begin
         drain_go_s = 1'b0;
      end
   end

   // Sequencer FSM with registered flush/redirect outputs and the pending latch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r        <= ST_RUN;
         flush_cnt_r    <= 4'd0;
         flush_r        <= 1'b0;
         new_pc_r       <= 32'd0;
         new_pc_valid_r <= 1'b0;
         pend_valid_r   <= 1'b0;
         pend_pc_r      <= 32'd0;
      end else begin
         case (state_r)
            ST_RUN: begin
               if (redirect_req_s) begin
                  state_r        <= ST_FLUSH;
                  flush_cnt_r    <= 4'd1;
                  flush_r        <= 1'b1;
                  new_pc_r       <= redirect_pc_s;
                  new_pc_valid_r <= 1'b1;
               end
            end
            ST_FLUSH: begin
               new_pc_valid_r <= 1'b0;
               if (flush_cnt_r >= FLUSH_LAST) begin
                  state_r <= ST_DRAIN;
                  flush_r <= 1'b0;
               end else begin
                  flush_cnt_r <= flush_cnt_r + 4'd1;
               end
               // An ERET never displaces a queued redirect; an exception always does.
               if (bus.excp_req) begin
                  pend_valid_r <= 1'b1;
                  pend_pc_r    <= bus.excp_vector;
               end else if (bus.eret_req && !pend_valid_r) begin
                  pend_valid_r <= 1'b1;
                  pend_pc_r    <= bus.epc_i;
               end
            end
            ST_DRAIN: begin
               pend_valid_r <= 1'b0;
               if (drain_go_s) begin
                  state_r        <= ST_FLUSH;
                  flush_cnt_r    <= 4'd1;
                  flush_r        <= 1'b1;
                  new_pc_r       <= drain_pc_s;
                  new_pc_valid_r <= 1'b1;
               end else begin
                  state_r <= ST_RUN;
               end
            end
            default: begin
               state_r        <= ST_RUN;
               flush_r        <= 1'b0;
               new_pc_valid_r <= 1'b0;
               pend_valid_r   <= 1'b0;
            end
         endcase
      end
   end

   // Watchdog: count consecutive stalled RUN cycles, sticky flag at the limit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_cnt_r        <= 16'd0;
         stall_timeout_r <= 1'b0;
      end else if (stall_s != 6'b000000) begin
         wd_cnt_r <= wd_inc_s;
         if (wd_inc_s >= STALL_LIMIT) begin
            stall_timeout_r <= 1'b1;
         end
      end else begin
         wd_cnt_r <= 16'd0;
      end
   end

   assign bus.stall         = stall_s;
   assign bus.flush         = flush_r;
   assign bus.new_pc        = new_pc_r;
   assign bus.new_pc_valid  = new_pc_valid_r;
   assign bus.stall_timeout = stall_timeout_r;
   assign bus.busy          = (state_r != ST_RUN);

`ifdef PIPE_CTRL_PERF_EN
   logic        take_s;
   logic [31:0] perf_stall_cnt_r;
   logic [31:0] perf_flush_cnt_r;

   assign take_s = ((state_r == ST_RUN) && redirect_req_s) ||
                   ((state_r == ST_DRAIN) && drain_go_s);

   // Free-running performance counters, wrapping at 2^32.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_stall_cnt_r <= 32'd0;
         perf_flush_cnt_r <= 32'd0;
      end else begin
         if (stall_s != 6'b000000) begin
            perf_stall_cnt_r <= perf_stall_cnt_r + 32'd1;
         end
         if (take_s) begin
            perf_flush_cnt_r <= perf_flush_cnt_r + 32'd1;
         end
      end
   end

   assign bus.perf_stall_cnt = perf_stall_cnt_r;
   assign bus.perf_flush_cnt = perf_flush_cnt_r;
`else
   // Performance counters not built.
`endif
endmodule
